// File: rtl/risc8_pkg.sv
// risc8_pkg: shared types and constants for the risc8 core and its boot loader.
`default_nettype none
package risc8_pkg;

  localparam int BYTE_W  = 8;
  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_W_LO   = 3'd2,
    S_W_HI   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/risc8_boot_loader.sv
// risc8_boot_loader: receives a length-prefixed, checksummed byte stream, writes
// 16-bit instruction words into instruction memory and holds the core until the image is good.
`default_nettype none
module risc8_boot_loader
  import risc8_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BYTE_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               reload,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error
);

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  loader_state_t     state;
  logic [15:0]       len;
  logic [15:0]       count;
  logic [BYTE_W-1:0] csum;
  logic [BYTE_W-1:0] lo_byte;
  logic [ADDR_W-1:0] widx;

  logic              accept;
  logic [15:0]       len_in;
  logic [15:0]       count_next;

  assign in_ready   = (state != S_DONE) && (state != S_ERR);
  assign accept     = in_valid && in_ready;
  // LEN_LO is parked in lo_byte, so the full length is known while LEN_HI is on the bus.
  assign len_in     = {in_data, lo_byte};
  assign count_next = count + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_LEN_LO;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      len        <= '0;
      count      <= '0;
      csum       <= '0;
      lo_byte    <= '0;
      widx       <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_DONE, S_ERR: begin
          if (reload) begin
            state    <= S_LEN_LO;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            csum     <= '0;
            count    <= '0;
            widx     <= '0;
          end
        end
        default: begin
          if (accept) begin
            if (state != S_CSUM) csum <= csum + in_data;
            case (state)
              S_LEN_LO: begin
                lo_byte <= in_data;
                state   <= S_LEN_HI;
              end
              S_LEN_HI: begin
                len <= len_in;
                if ({1'b0, len_in} > MAX_WORDS) begin
                  state <= S_ERR;
                  error <= 1'b1;
                end else if (len_in == 16'd0) begin
                  state <= S_CSUM;
                end else begin
                  state <= S_W_LO;
                end
              end
              S_W_LO: begin
                lo_byte <= in_data;
                state   <= S_W_HI;
              end
              S_W_HI: begin
                imem_we    <= 1'b1;
                imem_wdata <= {in_data, lo_byte};
                imem_addr  <= widx;
                widx       <= widx + ADDR_W'(1);
                count      <= count_next;
                state      <= (count_next == len) ? S_CSUM : S_W_LO;
              end
              S_CSUM: begin
                if (in_data == csum) begin
                  state    <= S_DONE;
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
                end else begin
                  state <= S_ERR;
                  error <= 1'b1;
                end
              end
              default: state <= S_ERR;
            endcase
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_risc8_boot_loader.sv
// tb_risc8_boot_loader: directed-vector self-checking bench for risc8_boot_loader.
`default_nettype none
module tb_risc8_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        reload;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  wr_addr[$];
  logic [15:0] wr_data[$];

  always #5 clk = ~clk;

  risc8_boot_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  // Every cycle with imem_we high is logged as one write.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int i = 0; i < gap; i++) tick();
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin
      tick();
      t++;
    end
    if (t >= 20) check_eq("ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_ready"}, 32'(in_ready),   32'd1);
    check_eq({tag, "_we"},    32'(imem_we),    32'd0);
    check_eq({tag, "_addr"},  32'(imem_addr),  32'd0);
    check_eq({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
    check_eq({tag, "_hold"},  32'(cpu_hold),   32'd1);
    check_eq({tag, "_done"},  32'(done),       32'd0);
    check_eq({tag, "_error"}, 32'(error),      32'd0);
  endtask

  task automatic check_two_writes(input string tag);
    check_eq({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check_eq({tag, "_a0"}, 32'(wr_addr[0]), 32'd0);
      check_eq({tag, "_d0"}, 32'(wr_data[0]), 32'h1234);
      check_eq({tag, "_a1"}, 32'(wr_addr[1]), 32'd1);
      check_eq({tag, "_d1"}, 32'(wr_data[1]), 32'hABCD);
    end
  endtask

  logic [7:0] good_img[7];
  int         gaps[7];

  initial begin
    good_img = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hC0};
    gaps     = '{0, 3, 0, 1, 2, 0, 3};
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check_reset_values("rst");

    // Good image, continuous valid; write pulse checked right after each high byte.
    wr_addr.delete(); wr_data.delete();
    for (int i = 0; i < 7; i++) begin
      send_byte(good_img[i], 0);
      if (i == 3) begin
        check_eq("g_we0",   32'(imem_we),    32'd1);
        check_eq("g_addr0", 32'(imem_addr),  32'd0);
        check_eq("g_data0", 32'(imem_wdata), 32'h1234);
      end
      if (i == 4) check_eq("g_we_pulse", 32'(imem_we), 32'd0);
    end
    check_eq("g_done",  32'(done),     32'd1);
    check_eq("g_hold",  32'(cpu_hold), 32'd0);
    check_eq("g_error", 32'(error),    32'd0);
    check_eq("g_ready", 32'(in_ready), 32'd0);
    tick();
    check_two_writes("g");

    // Bad checksum.
    pulse_reload();
    wr_addr.delete(); wr_data.delete();
    for (int i = 0; i < 6; i++) send_byte(good_img[i], 0);
    send_byte(8'hC1, 0);
    check_eq("b_error", 32'(error),    32'd1);
    check_eq("b_hold",  32'(cpu_hold), 32'd1);
    check_eq("b_done",  32'(done),     32'd0);
    check_eq("b_ready", 32'(in_ready), 32'd0);
    tick();
    check_two_writes("b");

    // Length overflow: N = 257 with ADDR_W = 8.
    pulse_reload();
    check_eq("ov_ready_after_reload", 32'(in_ready), 32'd1);
    check_eq("ov_error_cleared",      32'(error),    32'd0);
    wr_addr.delete(); wr_data.delete();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check_eq("ov_error", 32'(error),    32'd1);
    check_eq("ov_ready", 32'(in_ready), 32'd0);
    tick(); tick();
    check_eq("ov_nwr", 32'(wr_addr.size()), 32'd0);

    // Boundary: N = 256 is accepted, so the loader must still take data bytes.
    pulse_reload();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    check_eq("max_len_error", 32'(error),    32'd0);
    check_eq("max_len_ready", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Empty image.
    wr_addr.delete(); wr_data.delete();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check_eq("e_done", 32'(done),     32'd1);
    check_eq("e_hold", 32'(cpu_hold), 32'd0);
    tick();
    check_eq("e_nwr", 32'(wr_addr.size()), 32'd0);

    // Good image with stalls between bytes.
    pulse_reload();
    wr_addr.delete(); wr_data.delete();
    for (int i = 0; i < 7; i++) send_byte(good_img[i], gaps[i]);
    check_eq("s_done", 32'(done), 32'd1);
    tick();
    check_two_writes("s");

    // Reload, then a one-word image.
    pulse_reload();
    check_eq("r_hold",  32'(cpu_hold), 32'd1);
    check_eq("r_done",  32'(done),     32'd0);
    check_eq("r_ready", 32'(in_ready), 32'd1);
    wr_addr.delete(); wr_data.delete();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hAE, 0);
    check_eq("r2_done", 32'(done), 32'd1);
    tick();
    check_eq("r2_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check_eq("r2_a0", 32'(wr_addr[0]), 32'd0);
      check_eq("r2_d0", 32'(wr_data[0]), 32'hBEEF);
    end

    // Reset after LEN_HI, then a fresh good image.
    pulse_reload();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("mid");
    wr_addr.delete(); wr_data.delete();
    for (int i = 0; i < 7; i++) send_byte(good_img[i], 0);
    check_eq("m_done", 32'(done),     32'd1);
    check_eq("m_hold", 32'(cpu_hold), 32'd0);
    tick();
    check_two_writes("m");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
